// File: rtl/safety_boot_seq.sv
// -----------------------------------------------------------------------------
// safety_boot_seq
//
// Autonomous boot sequencer for the safety island. On a start pulse it writes
// the boot address and the fetch-enable register of the SoC control block over
// the peripheral register bus. It then polls the core-status register every
// PollCycles idle cycles until the end-of-computation bit (bit 31) is set, and
// reports the exit code held in bits [30:0].
//
// Ports
//   clk_i, rst_i         clock, asynchronous active-high reset
//   start_i              start pulse (accepted only when idle or done)
//   boot_addr_i          boot address to write, sampled at start
//   max_polls_i          status poll budget, 0 = unlimited, sampled at start
//   req_o/addr_o/we_o/wdata_o/be_o   bus request channel (master side)
//   gnt_i                grant; a transfer is taken when req_o && gnt_i
//   rvalid_i/rdata_i/err_i           bus response channel
//   busy_o               sequence in progress
//   done_o               sequence finished, held until the next start
//   exit_code_o          core-status bits [30:0] at completion
//   success_o            finished cleanly with exit code 0
//   timeout_o            poll budget exhausted
//   bus_err_o            a bus response reported an error
// All outputs are registered.
// -----------------------------------------------------------------------------
module safety_boot_seq #(
   parameter int unsigned              AddrWidth        = 32,
   parameter logic [AddrWidth-1:0]     SocCtrlBase      = 32'h0020_0000,
   parameter logic [AddrWidth-1:0]     BootAddrOffset   = 32'h0,
   parameter logic [AddrWidth-1:0]     FetchEnOffset    = 32'h4,
   parameter logic [AddrWidth-1:0]     CoreStatusOffset = 32'h8,
   parameter int unsigned              PollCycles       = 1024
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [31:0]          boot_addr_i,
   input  logic [15:0]          max_polls_i,
   output logic                 req_o,
   output logic [AddrWidth-1:0] addr_o,
   output logic                 we_o,
   output logic [31:0]          wdata_o,
   output logic [3:0]           be_o,
   input  logic                 gnt_i,
   input  logic                 rvalid_i,
   input  logic [31:0]          rdata_i,
   input  logic                 err_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [30:0]          exit_code_o,
   output logic                 success_o,
   output logic                 timeout_o,
   output logic                 bus_err_o
);

   localparam logic [3:0] S_IDLE         = 4'd0;
   localparam logic [3:0] S_WR_BOOT      = 4'd1;
   localparam logic [3:0] S_WR_BOOT_RSP  = 4'd2;
   localparam logic [3:0] S_WR_FETCH     = 4'd3;
   localparam logic [3:0] S_WR_FETCH_RSP = 4'd4;
   localparam logic [3:0] S_WAIT         = 4'd5;
   localparam logic [3:0] S_RD_STAT      = 4'd6;
   localparam logic [3:0] S_RD_STAT_RSP  = 4'd7;
   localparam logic [3:0] S_DONE         = 4'd8;

   localparam logic [AddrWidth-1:0] BootAddr   = SocCtrlBase + BootAddrOffset;
   localparam logic [AddrWidth-1:0] FetchAddr  = SocCtrlBase + FetchEnOffset;
   localparam logic [AddrWidth-1:0] StatusAddr = SocCtrlBase + CoreStatusOffset;
   localparam logic [31:0]          WaitLoad   = 32'(PollCycles - 1);

   logic [3:0]           state_q, state_d;
   logic [31:0]          boot_addr_q, boot_addr_d;
   logic [15:0]          max_polls_q, max_polls_d;
   logic [15:0]          poll_cnt_q, poll_cnt_d;
   logic [15:0]          poll_nxt;
   logic [31:0]          wait_cnt_q, wait_cnt_d;
   logic                 req_q, req_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic                 we_q, we_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [3:0]           be_q, be_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [30:0]          exit_code_q, exit_code_d;
   logic                 success_q, success_d;
   logic                 timeout_q, timeout_d;
   logic                 bus_err_q, bus_err_d;

   always_comb begin
      state_d     = state_q;
      boot_addr_d = boot_addr_q;
      max_polls_d = max_polls_q;
      poll_cnt_d  = poll_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      exit_code_d = exit_code_q;
      success_d   = success_q;
      timeout_d   = timeout_q;
      bus_err_d   = bus_err_q;
      // Saturating increment: an unlimited run can never wrap into a
      // count that matches a budget.
      poll_nxt    = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               boot_addr_d = boot_addr_i;
               max_polls_d = max_polls_i;
               poll_cnt_d  = 16'd0;
               exit_code_d = 31'd0;
               success_d   = 1'b0;
               timeout_d   = 1'b0;
               bus_err_d   = 1'b0;
               state_d     = S_WR_BOOT;
            end
         end
         S_WR_BOOT: begin
            if (gnt_i) state_d = S_WR_BOOT_RSP;
         end
         S_WR_BOOT_RSP: begin
            if (rvalid_i) begin
               if (err_i) begin
                  bus_err_d = 1'b1;
                  state_d   = S_DONE;
               end else begin
                  state_d   = S_WR_FETCH;
               end
            end
         end
         S_WR_FETCH: begin
            if (gnt_i) state_d = S_WR_FETCH_RSP;
         end
         S_WR_FETCH_RSP: begin
            if (rvalid_i) begin
               if (err_i) begin
                  bus_err_d  = 1'b1;
                  state_d    = S_DONE;
               end else begin
                  wait_cnt_d = WaitLoad;
                  state_d    = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (wait_cnt_q == 32'd0) state_d = S_RD_STAT;
            else                     wait_cnt_d = wait_cnt_q - 32'd1;
         end
         S_RD_STAT: begin
            if (gnt_i) state_d = S_RD_STAT_RSP;
         end
         S_RD_STAT_RSP: begin
            if (rvalid_i) begin
               if (err_i) begin
                  bus_err_d   = 1'b1;
                  state_d     = S_DONE;
               end else if (rdata_i[31]) begin
                  exit_code_d = rdata_i[30:0];
                  success_d   = (rdata_i[30:0] == 31'd0);
                  state_d     = S_DONE;
               end else begin
                  poll_cnt_d  = poll_nxt;
                  if ((max_polls_q != 16'd0) && (poll_nxt == max_polls_q)) begin
                     timeout_d = 1'b1;
                     state_d   = S_DONE;
                  end else begin
                     wait_cnt_d = WaitLoad;
                     state_d    = S_WAIT;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Bus request fields are decoded from the next state so they are
      // registered together and remain stable for as long as a request
      // state is held waiting for grant.
      req_d   = 1'b0;
      addr_d  = '0;
      we_d    = 1'b0;
      wdata_d = 32'd0;
      be_d    = 4'h0;
      case (state_d)
         S_WR_BOOT: begin
            req_d   = 1'b1;
            addr_d  = BootAddr;
            we_d    = 1'b1;
            wdata_d = boot_addr_d;
            be_d    = 4'hF;
         end
         S_WR_FETCH: begin
            req_d   = 1'b1;
            addr_d  = FetchAddr;
            we_d    = 1'b1;
            wdata_d = 32'h1;
            be_d    = 4'hF;
         end
         S_RD_STAT: begin
            req_d   = 1'b1;
            addr_d  = StatusAddr;
            be_d    = 4'hF;
         end
         default: ;
      endcase

      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         boot_addr_q <= 32'd0;
         max_polls_q <= 16'd0;
         poll_cnt_q  <= 16'd0;
         wait_cnt_q  <= 32'd0;
         req_q       <= 1'b0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= 32'd0;
         be_q        <= 4'h0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         exit_code_q <= 31'd0;
         success_q   <= 1'b0;
         timeout_q   <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         boot_addr_q <= boot_addr_d;
         max_polls_q <= max_polls_d;
         poll_cnt_q  <= poll_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         req_q       <= req_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         exit_code_q <= exit_code_d;
         success_q   <= success_d;
         timeout_q   <= timeout_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign req_o       = req_q;
   assign addr_o      = addr_q;
   assign we_o        = we_q;
   assign wdata_o     = wdata_q;
   assign be_o        = be_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign exit_code_o = exit_code_q;
   assign success_o   = success_q;
   assign timeout_o   = timeout_q;
   assign bus_err_o   = bus_err_q;

endmodule

// File: doc/safety_boot_seq.md
# safety_boot_seq

Hardware boot sequencer for the safety island. On a start pulse it writes the boot address and fetch-enable registers in the SoC control block. It then polls the core-status register at a fixed interval until the end-of-computation bit is set, and reports the exit code. This replaces the JTAG-driven boot/poll flow for autonomous boot. It sits as an additional master on the peripheral register bus, in front of the SoC control registers.

## Interface
- AddrWidth, 32, register bus address width
- SocCtrlBase, 32'h0020_0000, SoC control block base address
- BootAddrOffset, 32'h0, boot address register offset
- FetchEnOffset, 32'h4, fetch-enable register offset
- CoreStatusOffset, 32'h8, core-status register offset
- PollCycles, 1024, idle cycles between status reads (>=1)
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, asynchronous, active-high
- start_i  in  1  start pulse, accepted only in IDLE or DONE
- boot_addr_i  in  32  value written to the boot address register, sampled at start
- max_polls_i  in  16  poll budget; 0 = unlimited; sampled at start
- req_o  out  1  bus request
- addr_o  out  AddrWidth  bus address
- we_o  out  1  1 = write
- wdata_o  out  32  write data
- be_o  out  4  byte enables, always 4'hF
- gnt_i  in  1  grant; a transfer is accepted when req_o && gnt_i
- rvalid_i  in  1  response valid, at least 1 cycle after grant
- rdata_i  in  32  read data, valid with rvalid_i
- err_i  in  1  response error, valid with rvalid_i
- busy_o  out  1  sequence in progress
- done_o  out  1  sequence finished; held until next start
- exit_code_o  out  31  core-status bits [30:0] at completion
- success_o  out  1  done_o && no error/timeout && exit_code_o == 0
- timeout_o  out  1  poll budget exhausted
- bus_err_o  out  1  a bus response carried err_i

## Operation
- States: IDLE, WR_BOOT, WR_BOOT_RSP, WR_FETCH, WR_FETCH_RSP, WAIT, RD_STAT, RD_STAT_RSP, DONE.
- IDLE/DONE + start_i:
  - latch boot_addr_i and max_polls_i
  - clear done_o, exit_code_o, timeout_o and bus_err_o
  - go to WR_BOOT
- WR_BOOT: req_o=1, we_o=1, addr=SocCtrlBase+BootAddrOffset, wdata=latched boot address. Hold until gnt_i, then go to WR_BOOT_RSP.
- WR_FETCH: write 32'h1 to SocCtrlBase+FetchEnOffset. Same handshake, then go to WR_FETCH_RSP.
- *_RSP states wait for rvalid_i:
  - if err_i, set bus_err_o and go to DONE
  - otherwise go to the next state
- WAIT: load the down-counter with PollCycles-1 and count to 0, then go to RD_STAT.
- RD_STAT: req_o=1, we_o=0, addr=SocCtrlBase+CoreStatusOffset. Hold until gnt_i.
- RD_STAT_RSP, on rvalid_i:
  - err_i: set bus_err_o, go to DONE.
  - rdata_i[31]=1: exit_code_o <= rdata_i[30:0], go to DONE.
  - otherwise increment the 16-bit poll counter. If max_polls_i != 0 and the count equals max_polls_i, set timeout_o and go to DONE. Otherwise go to WAIT.
- Request fields (addr_o, we_o, wdata_o) stay stable while req_o=1 and gnt_i=0.
- req_o never drops before grant.
- start_i while busy is ignored.
- Outside request states, addr_o/wdata_o/we_o are 0.

## Timing
- Reset values:
  - all outputs 0
  - state IDLE; counters 0
- Reset mid-transfer returns to IDLE immediately and deasserts req_o asynchronously. An outstanding response arriving later is ignored.
- All outputs are registered.
- busy_o=1 in every state except IDLE and DONE.
- done_o is asserted in the cycle DONE is entered.
- Best-case latency with zero-wait bus (gnt same cycle, rvalid next cycle), start at cycle 0:
  - boot write req at cycle 1
  - fetch write req at cycle 3
  - WAIT occupies cycles 5..4+PollCycles
  - first status req at cycle 5+PollCycles
  - done_o at cycle 7+PollCycles if EOC is already set
- Poll period: PollCycles + 2 + bus latency cycles.
- Poll counter saturates at 16'hFFFF when unlimited (max_polls_i=0). It never wraps into a false timeout.
- start_i and gnt_i in the same cycle in DONE: start is accepted; gnt_i is ignored because req_o=0.

## Test plan
- Zero-wait bus, boot_addr_i=32'h0001_0000, status reads return 0 twice then 32'h8000_0000:
  - writes go to 0x0020_0000 (data 0x0001_0000) and 0x0020_0004 (data 1)
  - 3 reads occur; done_o=1, success_o=1, exit_code_o=0
- Status returns 32'h8000_0005: done_o=1, exit_code_o=31'h5, success_o=0, timeout_o=0.
- Grant delayed 7 cycles on every transfer: req_o and address/data stay stable for all 7 cycles; same final result as the first scenario.
- max_polls_i=3, status always 0: exactly 3 reads, then timeout_o=1, done_o=1, success_o=0.
- err_i on the fetch-enable write response: bus_err_o=1, done_o=1, and no status read is issued.
- rst_i asserted during RD_STAT with req_o=1: req_o=0 in the same cycle, all outputs 0. A new start_i after reset re-runs the full sequence from the boot write.
